// File: rtl/flappy_pkg.sv
// ---------------------------------------------------------------------------
// flappy_pkg -- constants and types shared by the LED-column shifters.
//   ROWS          : number of LED rows in one column
//   col_t         : one column pattern, bit i = row i lit
//   PIPE_GAP_DEF  : default number of empty columns between two pipes
// ---------------------------------------------------------------------------
package flappy_pkg;
  localparam int ROWS         = 16;
  localparam int PIPE_GAP_DEF = 3;

  typedef logic [ROWS-1:0] col_t;
endpackage

// File: rtl/shifter_right_col_gap_counter.sv
// ---------------------------------------------------------------------------
// gap_counter -- counts the empty columns still owed before the next pipe.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset, clears the count
//   clr_i      : synchronous clear (highest priority)
//   load_i     : load load_val_i (a pipe was just injected)
//   dec_i      : decrement by one (an empty column was just shifted in)
//   load_val_i : reload value
//   zero_o     : count is zero, next shift injects a pipe
// ---------------------------------------------------------------------------
module gap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (dec_i)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/shifter_right_col.sv
// ---------------------------------------------------------------------------
// shifter_right_col -- rightmost LED column of the scrolling pipe field.
// On every shift strobe the column either takes a fresh pipe pattern or,
// while the gap counter is running, an empty/fill column.
//   PIPE_GAP  : empty columns between consecutive pipes (0..15)
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   clkP      : shift strobe
//   clkM      : restart strobe, clears column and gap counter
//   gameover  : freezes the column while high
//   newPipe   : pipe pattern injected when the gap count is exhausted
//   pipeRight : fill column for non-pipe shifts (default build)
//   pipeLeft  : fill column for non-pipe shifts when wrapping
//   curCol    : registered column pattern
// Build option: define SHIFTER_RIGHT_WRAP_EN to fill from pipeLeft
// (circular scroll) instead of pipeRight.
// ---------------------------------------------------------------------------
module shifter_right_col
  import flappy_pkg::*;
#(
  parameter int PIPE_GAP = PIPE_GAP_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  clkP,
  input  logic  clkM,
  input  logic  gameover,
  input  col_t  newPipe,
  input  col_t  pipeRight,
  input  col_t  pipeLeft,
  output col_t  curCol
);
  col_t curCol_q, curCol_d;
  col_t fill;
  logic gap_zero;
  logic shift, load, dec;

`ifdef SHIFTER_RIGHT_WRAP_EN
  assign fill = pipeLeft;
  logic unused_fill;
  assign unused_fill = ^pipeRight;
`else
  assign fill = pipeRight;
  logic unused_fill;
  assign unused_fill = ^pipeLeft;
`endif

  // clkM overrides everything; gameover blocks the strobe.
  assign shift = clkP & ~gameover & ~clkM;
  assign load  = shift &  gap_zero;
  assign dec   = shift & ~gap_zero;

  gap_counter #(.W(4)) u_gap (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (clkM),
    .load_i     (load),
    .dec_i      (dec),
    .load_val_i (4'(PIPE_GAP)),
    .zero_o     (gap_zero)
  );

  always_comb begin
    curCol_d = curCol_q;
    if (clkM)      curCol_d = '0;
    else if (load) curCol_d = newPipe;
    else if (dec)  curCol_d = fill;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) curCol_q <= '0;
    else        curCol_q <= curCol_d;
  end

  assign curCol = curCol_q;
endmodule

// File: tb/tb_shifter_right_col.sv
module tb_shifter_right_col;
  localparam int PG = 3;
`ifdef SHIFTER_RIGHT_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clkP, clkM, gameover;
  logic [15:0] newPipe, pipeRight, pipeLeft, curCol;

  int errors = 0;
  int checks = 0;

  shifter_right_col #(.PIPE_GAP(PG)) dut (
    .clk(clk), .reset(reset), .clkP(clkP), .clkM(clkM), .gameover(gameover),
    .newPipe(newPipe), .pipeRight(pipeRight), .pipeLeft(pipeLeft), .curCol(curCol)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        m, go, p;
    logic [15:0] np, pr, pl, exp;
  } vec_t;

  vec_t tbl[13];

  // behavioural model state
  logic [15:0] m_col;
  int          m_gap;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive just after a falling edge, sample at the following falling edge
  task automatic cyc(input logic m, input logic go, input logic p,
                     input logic [15:0] np, input logic [15:0] pr, input logic [15:0] pl);
    clkM = m; gameover = go; clkP = p; newPipe = np; pipeRight = pr; pipeLeft = pl;
    @(negedge clk);
  endtask

  task automatic model_step(input logic m, input logic go, input logic p,
                            input logic [15:0] np, input logic [15:0] pr, input logic [15:0] pl);
    if (m) begin m_col = 16'h0; m_gap = 0; end
    else if (go) begin end
    else if (p) begin
      if (m_gap == 0) begin m_col = np; m_gap = PG; end
      else begin m_col = WRAP ? pl : pr; m_gap = m_gap - 1; end
    end
  endtask

  initial begin
    tbl[0]  = '{"first_shift",   0,0,1, 16'hCCCC,16'h0000,16'h0000, 16'hCCCC};
    tbl[1]  = '{"gameover_hold", 0,1,1, 16'h1111,16'hFFFF,16'hFFFF, 16'hCCCC};
    tbl[2]  = '{"second_shift",  0,0,1, 16'hCCCC,16'h0000,16'h9999, WRAP ? 16'h9999 : 16'h0000};
    tbl[3]  = '{"gap2",          0,0,1, 16'hCCCC,16'h0000,16'h0000, 16'h0000};
    tbl[4]  = '{"gap3",          0,0,1, 16'hCCCC,16'h0000,16'h0000, 16'h0000};
    tbl[5]  = '{"pipe_again",    0,0,1, 16'hCCCC,16'h0000,16'h0000, 16'hCCCC};
    tbl[6]  = '{"idle_hold",     0,0,0, 16'h3333,16'h7777,16'h7777, 16'hCCCC};
    tbl[7]  = '{"restart_all",   1,1,1, 16'hAAAA,16'h5555,16'h5555, 16'h0000};
    tbl[8]  = '{"after_restart", 0,0,1, 16'h5A5A,16'h0000,16'h0000, 16'h5A5A};
    tbl[9]  = '{"fill_a",        0,0,1, 16'hFFFF,16'h00F0,16'h0F00, WRAP ? 16'h0F00 : 16'h00F0};
    tbl[10] = '{"fill_held",     0,0,1, 16'hFFFF,16'h1234,16'h4321, WRAP ? 16'h4321 : 16'h1234};
    tbl[11] = '{"fill_last",     0,0,1, 16'hFFFF,16'h0000,16'h0000, 16'h0000};
    tbl[12] = '{"pipe_8001",     0,0,1, 16'h8001,16'h0000,16'h0000, 16'h8001};

    reset = 1'b0; clkP = 0; clkM = 0; gameover = 0;
    newPipe = 0; pipeRight = 0; pipeLeft = 0;
    repeat (2) @(negedge clk);
    check("reset_state", curCol, 16'h0000);
    reset = 1'b1;

    // load FFFF then reset asynchronously mid-cycle
    cyc(0,0,1, 16'hFFFF,0,0);
    check("load_ffff", curCol, 16'hFFFF);
    clkP = 0;
    #1 reset = 1'b0;
    #1 check("async_reset", curCol, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].m, tbl[i].go, tbl[i].p, tbl[i].np, tbl[i].pr, tbl[i].pl);
      check(tbl[i].name, curCol, tbl[i].exp);
    end

    // sync model with a restart, then random traffic
    cyc(1,0,0, 0,0,0);
    check("sync_restart", curCol, 16'h0000);
    m_col = 16'h0; m_gap = 0;
    for (int k = 0; k < 400; k++) begin
      logic m, go, p;
      logic [15:0] np, pr, pl;
      m  = ($urandom_range(0,19) == 0);
      go = ($urandom_range(0,6) == 0);
      p  = ($urandom_range(0,2) != 0);
      np = 16'($urandom); pr = 16'($urandom); pl = 16'($urandom);
      if ($urandom_range(0,49) == 0) begin
        clkP = 0; clkM = 0;
        #1 reset = 1'b0;
        #1 check("rand_async_reset", curCol, 16'h0000);
        m_col = 16'h0; m_gap = 0;
        @(negedge clk);
        reset = 1'b1;
      end
      cyc(m, go, p, np, pr, pl);
      model_step(m, go, p, np, pr, pl);
      check("random", curCol, m_col);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shifter_right_col.md
SHIFTER_RIGHT_COL -- requirements
Module: shifterRight

Interface
REQ-001 Parameter: PIPE_GAP, default 3, number of empty columns shifted in between consecutive pipes (legal 0..15).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 clkP  input  1  shift strobe, one clk cycle wide, synchronous to clk.
REQ-005 clkM  input  1  restart strobe, synchronous to clk; clears column and gap counter.
REQ-006 gameover  input  1  level; freezes the column while high.
REQ-007 newPipe  input  16  pipe pattern to inject; bit i = LED row i lit.
REQ-008 pipeRight  input  16  boundary-column pattern shifted in on non-pipe shifts (normally tied 0).
REQ-009 pipeLeft  input  16  left neighbour column; used only by the wrap feature (REQ-021).
REQ-010 curCol  output  16  registered pattern of this (rightmost) LED column.

Function
REQ-011 State: 16-bit column register (drives curCol) plus 4-bit gap counter gapCnt.
REQ-012 Priority per rising edge: clkM, then gameover, then clkP, else hold.
REQ-013 clkM=1: curCol <= 16'h0000, gapCnt <= 0, regardless of gameover or clkP.
REQ-014 gameover=1 (clkM=0): curCol and gapCnt hold; clkP ignored.
REQ-015 clkP=1, gameover=0, gapCnt==0: curCol <= newPipe, gapCnt <= PIPE_GAP.
REQ-016 clkP=1, gameover=0, gapCnt!=0: curCol <= fill source (pipeRight, or REQ-021), gapCnt <= gapCnt-1.
REQ-017 Latency: curCol reflects the load one clk edge after the strobe cycle; no combinational input-to-output path.
REQ-018 PIPE_GAP=0: every shift loads newPipe.
REQ-019 clkP held high for several cycles counts as one shift per cycle (no edge detection).

Reset
REQ-020 reset=0 immediately forces curCol=16'h0000 and gapCnt=0, independent of clk; first shift after release loads newPipe.

Configuration
REQ-021 Macro SHIFTER_RIGHT_WRAP_EN: defined, fill source in REQ-016 is pipeLeft (circular scroll) and pipeRight is ignored; undefined, fill source is pipeRight and pipeLeft is ignored.

Structure
REQ-022 Shared package (flappy_pkg) holds ROWS=16 constant, col_t 16-bit typedef, and default PIPE_GAP constant.
REQ-023 Optional sub-module gap_counter (load/decrement/zero flag); otherwise a single flat module.

Verification
REQ-024 Reset: reset=0 with curCol=16'hFFFF loaded -> curCol=16'h0000 immediately, before the next clk edge.
REQ-025 First shift: after reset release, clkP=1, newPipe=16'hCCCC -> curCol=16'hCCCC next edge, gapCnt=3.
REQ-026 Gameover freeze: curCol=16'hCCCC, gameover=1, clkP=1 -> curCol stays 16'hCCCC, gapCnt unchanged.
REQ-027 Gap sequence: PIPE_GAP=3, pipeRight=0, newPipe=16'hCCCC, 5 single-cycle clkP pulses -> curCol = CCCC, 0000, 0000, 0000, CCCC.
REQ-028 Wrap (macro defined): pipeLeft=16'h9999, second shift -> curCol=16'h9999; macro undefined, same stimulus -> curCol=pipeRight.
REQ-029 Restart: clkM=1 coincident with clkP=1 and gameover=1 -> curCol=16'h0000, next clkP loads newPipe.
